// File: rtl/gcd_core.sv
// -----------------------------------------------------------------------------
// gcd_core
//
// Iterative greatest-common-divisor engine for unsigned operands using
// Euclid's subtraction method, one subtraction per clock.
//
// A request is accepted on a rising edge where valid_i=1 and the engine is
// idle. The result is published in gcd_o together with a one-cycle valid_o
// strobe. gcd_o then holds that value until the next result or a reset.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   reset_i  : synchronous active-low reset
//   valid_i  : start strobe, honoured only while idle
//   a_i, b_i : unsigned operands, sampled only on the accept edge
//   gcd_o    : result register, holds the last result
//   valid_o  : registered one-cycle result strobe
// -----------------------------------------------------------------------------
module gcd_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] gcd_o,
    output logic             valid_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             a_zero_s;
    logic             b_zero_s;
    logic             a_eq_b_s;
    logic             a_gt_b_s;
    logic [WIDTH-1:0] a_minus_b_s;
    logic [WIDTH-1:0] b_minus_a_s;

    // Operand comparisons and both candidate differences for the current step.
    always_comb begin
        a_zero_s    = (a_r == {WIDTH{1'b0}});
        b_zero_s    = (b_r == {WIDTH{1'b0}});
        a_eq_b_s    = (a_r == b_r);
        a_gt_b_s    = (a_r > b_r);
        a_minus_b_s = a_r - b_r;
        b_minus_a_s = b_r - a_r;
    end

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            gcd_o   <= {WIDTH{1'b0}};
            valid_o <= 1'b0;
        end else begin
            // The strobe is only raised on a result edge, so it is one cycle wide.
            valid_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        a_r     <= a_i;
                        b_r     <= b_i;
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Termination checks come first; a zero operand means the
                    // other operand is the answer (and gcd(0,0)=0 falls out).
                    if (b_zero_s) begin
                        gcd_o   <= a_r;
                        valid_o <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (a_zero_s) begin
                        gcd_o   <= b_r;
                        valid_o <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (a_eq_b_s) begin
                        gcd_o   <= a_r;
                        valid_o <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (a_gt_b_s) begin
                        // Larger minus smaller, so no underflow.
                        a_r <= a_minus_b_s;
                    end else begin
                        b_r <= b_minus_a_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_core.sv
// -----------------------------------------------------------------------------
// tb_gcd_core
//
// Directed self-checking bench for gcd_core (WIDTH=8). Expected results and
// result-edge latencies are hand-computed from Euclid's subtraction sequence.
// -----------------------------------------------------------------------------
module tb_gcd_core;

    localparam int WIDTH  = 8;
    localparam int BUDGET = 300;

    logic             clk_i;
    logic             reset_i;
    logic             valid_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] gcd_o;
    logic             valid_o;

    int checks_cnt;
    int errors_cnt;
    int pulse_cnt;

    gcd_core #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .gcd_o   (gcd_o),
        .valid_o (valid_o)
    );

    // 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count every result strobe, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Wait for the result strobe after an accept edge; returns the edge index
    // of the result (0 on timeout).
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= BUDGET; k++) begin
            step();
            if (valid_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Issue one request, check result value and latency. With hold_chk set,
    // one more cycle is spent confirming the strobe dropped and gcd_o held.
    task automatic run_op(input string tag, input int a, input int b,
                          input int exp_gcd, input int exp_lat, input bit hold_chk);
        int lat;
        int p0;
        p0      = pulse_cnt;
        valid_i = 1'b1;
        a_i     = a[WIDTH-1:0];
        b_i     = b[WIDTH-1:0];
        step();                     // accept edge E0
        valid_i = 1'b0;
        a_i     = 8'hAA;            // operands must not matter after E0
        b_i     = 8'h55;
        wait_result(lat);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " gcd"}, int'(gcd_o), exp_gcd);
        if (hold_chk) begin
            step();
            check_eq({tag, " strobe width"}, int'(valid_o), 0);
            check_eq({tag, " gcd hold"}, int'(gcd_o), exp_gcd);
            check_eq({tag, " pulse count"}, pulse_cnt - p0, 1);
        end
    endtask

    initial begin
        int lat;
        int p0;
        checks_cnt = 0;
        errors_cnt = 0;
        pulse_cnt  = 0;
        reset_i    = 1'b0;
        valid_i    = 1'b1;
        a_i        = 8'd5;
        b_i        = 8'd10;

        // Reset held for two edges with a request pending.
        step();
        step();
        check_eq("reset valid_o", int'(valid_o), 0);
        check_eq("reset gcd_o", int'(gcd_o), 0);
        valid_i = 1'b0;
        reset_i = 1'b1;
        repeat (20) step();
        check_eq("reset no result", pulse_cnt, 0);

        // Nominal: (60,84) -> 12 at E5.
        run_op("nominal", 60, 84, 12, 5, 1'b1);
        repeat (5) step();
        check_eq("nominal gcd sticky", int'(gcd_o), 12);

        // Degenerate operands, all at E1.
        run_op("zero_zero", 0, 0, 0, 1, 1'b1);
        run_op("x_zero", 7, 0, 7, 1, 1'b1);
        run_op("zero_x", 0, 9, 9, 1, 1'b1);
        run_op("equal", 13, 13, 13, 1, 1'b1);

        // Worst case and coprime.
        run_op("worst_a", 255, 1, 1, 255, 1'b1);
        run_op("worst_b", 1, 255, 1, 255, 1'b1);
        run_op("coprime", 17, 5, 1, 7, 1'b1);

        // Busy: a second request at E2 is ignored.
        p0      = pulse_cnt;
        valid_i = 1'b1;
        a_i     = 8'd60;
        b_i     = 8'd84;
        step();                     // E0
        valid_i = 1'b0;
        step();                     // E1
        valid_i = 1'b1;
        a_i     = 8'd9;
        b_i     = 8'd6;
        step();                     // E2, request dropped
        valid_i = 1'b0;
        wait_result(lat);
        check_eq("busy latency", lat + 2, 5);
        check_eq("busy gcd", int'(gcd_o), 12);
        // Back-to-back: issue on the edge right after the result edge.
        run_op("b2b", 9, 6, 3, 3, 1'b0);
        repeat (10) step();
        check_eq("busy pulse count", pulse_cnt - p0, 2);
        check_eq("b2b gcd hold", int'(gcd_o), 3);

        // Reset mid-operation aborts the request.
        p0      = pulse_cnt;
        valid_i = 1'b1;
        a_i     = 8'd255;
        b_i     = 8'd1;
        step();                     // E0
        valid_i = 1'b0;
        repeat (9) step();          // up to E9
        reset_i = 1'b0;
        step();                     // E10 under reset
        check_eq("abort valid_o", int'(valid_o), 0);
        check_eq("abort gcd_o", int'(gcd_o), 0);
        reset_i = 1'b1;
        repeat (BUDGET) step();
        check_eq("abort no result", pulse_cnt - p0, 0);
        check_eq("abort gcd stays", int'(gcd_o), 0);
        run_op("after_abort", 48, 18, 6, 5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/gcd_core.md
# gcd_core

Iterative greatest-common-divisor engine for unsigned operands, computed by repeated subtraction (Euclid), one subtraction per clock. Pulse-accept, pulse-complete datapath block. Sits behind a simple valid strobe from a controlling block; emits a one-cycle result strobe with the result held until the next result.

## Interface
- WIDTH, default 8: operand and result width in bits, unsigned, WIDTH ≥ 2.

- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-low reset; sampled on the rising edge of clk_i.
- valid_i  input  1  start strobe; a_i/b_i are captured on the edge where valid_i=1 and the block is idle.
- a_i  input  WIDTH  operand A, unsigned.
- b_i  input  WIDTH  operand B, unsigned.
- gcd_o  output  WIDTH  result register; holds the last result.
- valid_o  output  1  registered one-cycle result strobe.

## Operation
- Internal registers: A, B (WIDTH each), state ∈ {IDLE, CALC}.
- Reset (reset_i=0 at an edge): state=IDLE, A=B=0, gcd_o=0, valid_o=0. Reset overrides every other action and aborts an in-flight computation; no valid_o is produced for the aborted request.
- IDLE: if valid_i=1, load A=a_i, B=b_i and go to CALC; otherwise hold.
- CALC, evaluated once per edge, in priority order:
  - B==0: gcd_o=A, valid_o=1, go to IDLE.
  - A==0: gcd_o=B, valid_o=1, go to IDLE.
  - A==B: gcd_o=A, valid_o=1, go to IDLE.
  - A>B: A=A−B.
  - else: B=B−A.
- Arithmetic is unsigned. Subtraction is always larger minus smaller, so it never underflows. No overflow is possible.
- Special cases: gcd(0,0)=0; gcd(x,0)=gcd(0,x)=x.
- valid_i during CALC is ignored. The request is dropped and the inputs are not buffered.
- valid_o is 0 on every edge that does not produce a result, so it is exactly one cycle wide.
- gcd_o changes only on a result edge or on reset.

## Timing
- Accept edge E0: the IDLE edge with valid_i=1.
- Result edge En: n = 1 + number of subtraction steps. valid_o and the new gcd_o are visible from En until E(n+1).
- Minimum latency is 1 edge: any zero operand, or equal operands.
- Worst case is 2^WIDTH − 1 edges (255 for WIDTH=8, e.g. 255,1).
- The block is back in IDLE in the same cycle that valid_o=1. A valid_i sampled on E(n+1) is accepted. Back-to-back issue is therefore possible one cycle after the result edge.
- Inputs a_i/b_i are sampled only at the accept edge. They may change freely afterwards.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_i=0 for 2 edges with valid_i=1, a_i=5, b_i=10 -> valid_o=0, gcd_o=0, no result ever appears.
- Nominal: release reset, pulse valid_i for one cycle with a_i=60, b_i=84 -> valid_o high for exactly one cycle, at E5, with gcd_o=12. gcd_o stays 12 afterwards.
- Degenerate operands:
  - (0,0) -> gcd_o=0 at E1.
  - (7,0) -> gcd_o=7 at E1.
  - (0,9) -> gcd_o=9 at E1.
  - (13,13) -> gcd_o=13 at E1.
- Worst case and coprime:
  - (255,1) -> gcd_o=1 at E255.
  - (1,255) -> gcd_o=1 at E255.
  - (17,5) -> gcd_o=1.
- Busy and back-to-back:
  - Issue (60,84), then pulse valid_i with (9,6) at E2 -> ignored; only result 12 appears.
  - Issue (9,6) on the edge after valid_o -> result 3.
- Reset mid-operation: issue (255,1), assert reset_i=0 at E10 -> valid_o never asserts, gcd_o=0. A following request (48,18) yields 6.
